// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing the single port of the 16x32 register bank,
// plus a sequenced clear that zeroes registers 1..15 one per cycle.
module reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_we_i,
  input  logic [NREQ*4-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [DW-1:0]     rsp_rdata_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              err_wr0_o,
  output logic [15:0]       bank_wr_o,
  output logic [3:0]        bank_rd_addr_o,
  output logic [DW-1:0]     bank_data_in_o,
  input  logic [DW-1:0]     bank_data_out_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [3:0]      clr_idx_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            clr_busy_q;
  logic            clr_done_q;
  logic            err_wr0_q;
  logic [3:0]      rd_addr_q;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     idx_sum;
  logic [PW:0]     rr_sum;
  logic [PW-1:0]   rr_ptr_d;
  logic            sel_we;
  logic [3:0]      sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            grant;

  // Search from rr_ptr upward, wrapping modulo NREQ; first pending request wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NREQ)) idx_sum = idx_sum - (PW+1)'(NREQ);
      if (!grant_found && req_valid_i[idx_sum[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_we    = req_we_i[i];
        sel_addr  = req_addr_i[4*i +: 4];
        sel_wdata = req_wdata_i[DW*i +: DW];
      end
    end
  end

  assign grant    = (state_q == SERVE) && !clr_start_i && grant_found;
  assign rr_sum   = {1'b0, grant_idx} + (PW+1)'(1);
  assign rr_ptr_d = (rr_sum == (PW+1)'(NREQ)) ? '0 : rr_sum[PW-1:0];

  // Writes to register 0 never reach the bank, so bank_wr[0] stays low.
  always_comb begin
    req_ready_o    = '0;
    bank_wr_o      = '0;
    bank_data_in_o = '0;
    bank_rd_addr_o = rd_addr_q;
    if (state_q == CLEAR) begin
      bank_wr_o = 16'(1) << clr_idx_q;
    end else if (grant) begin
      req_ready_o = REQ_ONE << grant_idx;
      if (sel_we) begin
        if (sel_addr != 4'd0) begin
          bank_wr_o      = 16'(1) << sel_addr;
          bank_data_in_o = sel_wdata;
        end
      end else begin
        bank_rd_addr_o = sel_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SERVE;
      rr_ptr_q    <= '0;
      clr_idx_q   <= 4'd1;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      err_wr0_q   <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      clr_done_q  <= 1'b0;
      case (state_q)
        SERVE: begin
          if (clr_start_i) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_idx_q  <= 4'd1;
          end else if (grant) begin
            rr_ptr_q <= rr_ptr_d;
            if (sel_we) begin
              if (sel_addr == 4'd0) err_wr0_q <= 1'b1;
            end else begin
              rsp_valid_q <= REQ_ONE << grant_idx;
              rsp_rdata_q <= (sel_addr == 4'd0) ? '0 : bank_data_out_i;
              rd_addr_q   <= sel_addr;
            end
          end
        end
        CLEAR: begin
          if (clr_idx_q == 4'd15) begin
            state_q    <= SERVE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
            clr_idx_q  <= 4'd1;
          end else begin
            clr_idx_q <= clr_idx_q + 4'd1;
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign clr_busy_o  = clr_busy_q;
  assign clr_done_o  = clr_done_q;
  assign err_wr0_o   = err_wr0_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: vector table for arbitration and
// access paths, hand sequences for the clear operation and reset abort.
module tb_reg_bank_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_we;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         clr_start;
  logic         clr_busy;
  logic         clr_done;
  logic         err_wr0;
  logic [15:0]  bank_wr;
  logic [3:0]   bank_rd_addr;
  logic [31:0]  bank_din;
  logic [31:0]  bank_dout;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.NREQ(4), .DW(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .err_wr0_o(err_wr0), .bank_wr_o(bank_wr), .bank_rd_addr_o(bank_rd_addr),
    .bank_data_in_o(bank_din), .bank_data_out_i(bank_dout)
  );

  // Register bank model: R0 is never written so always reads 0.
  logic [31:0] bank_q [16];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 1; i < 16; i++) if (bank_wr[i]) bank_q[i] <= bank_din;
    end
  end
  assign bank_dout = bank_q[bank_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   v;
    logic [3:0]   we;
    logic [15:0]  a;
    logic [127:0] wd;
    logic [3:0]   e_rdy;
    logic [15:0]  e_wr;
    logic [31:0]  e_din;
    logic [3:0]   e_rsp;
    logic [31:0]  e_rd;
    logic         e_err;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we,
                              input logic [15:0] a, input logic [127:0] wd,
                              input logic [3:0] e_rdy, input logic [15:0] e_wr,
                              input logic [31:0] e_din, input logic [3:0] e_rsp,
                              input logic [31:0] e_rd, input logic e_err);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.wd = wd; r.e_rdy = e_rdy; r.e_wr = e_wr;
    r.e_din = e_din; r.e_rsp = e_rsp; r.e_rd = e_rd; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [15:0] a,
                       input logic [127:0] wd, input logic clr);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; clr_start = clr;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] W2 = 128'h00000000_DEADBEEF_00000000_00000000;
  localparam logic [127:0] W3 = 128'h00000077_00000000_00000000_00000000;
  localparam logic [127:0] W0 = 128'h00000000_00000000_00000000_00001234;
  localparam logic [31:0]  DB = 32'hDEADBEEF;

  vec_t vecs [22];

  initial begin
    vecs[0]  = mk(4'h0, 4'h0, 16'h0000, '0, 4'h0, 16'h0000, 0,        4'h0, 0,  1'b0);
    vecs[1]  = mk(4'h4, 4'h4, 16'h0500, W2, 4'h4, 16'h0020, DB,       4'h0, 0,  1'b0);
    vecs[2]  = mk(4'h1, 4'h0, 16'h0005, '0, 4'h1, 16'h0000, 0,        4'h0, 0,  1'b0);
    vecs[3]  = mk(4'h0, 4'h0, 16'h0000, '0, 4'h0, 16'h0000, 0,        4'h1, DB, 1'b0);
    vecs[4]  = mk(4'h0, 4'h0, 16'h0000, '0, 4'h0, 16'h0000, 0,        4'h0, 0,  1'b0);
    vecs[5]  = mk(4'h8, 4'h8, 16'h7000, W3, 4'h8, 16'h0080, 32'h77,   4'h0, 0,  1'b0);
    vecs[6]  = mk(4'hF, 4'h0, 16'h5075, '0, 4'h1, 16'h0000, 0,        4'h0, 0,  1'b0);
    vecs[7]  = mk(4'hF, 4'h0, 16'h5075, '0, 4'h2, 16'h0000, 0,        4'h1, DB, 1'b0);
    vecs[8]  = mk(4'hF, 4'h0, 16'h5075, '0, 4'h4, 16'h0000, 0,        4'h2, 32'h77, 1'b0);
    vecs[9]  = mk(4'hF, 4'h0, 16'h5075, '0, 4'h8, 16'h0000, 0,        4'h4, 0,  1'b0);
    vecs[10] = mk(4'hF, 4'h0, 16'h5075, '0, 4'h1, 16'h0000, 0,        4'h8, DB, 1'b0);
    vecs[11] = mk(4'hF, 4'h0, 16'h5075, '0, 4'h2, 16'h0000, 0,        4'h1, DB, 1'b0);
    vecs[12] = mk(4'hF, 4'h0, 16'h5075, '0, 4'h4, 16'h0000, 0,        4'h2, 32'h77, 1'b0);
    vecs[13] = mk(4'hF, 4'h0, 16'h5075, '0, 4'h8, 16'h0000, 0,        4'h4, 0,  1'b0);
    vecs[14] = mk(4'h2, 4'h0, 16'h0070, '0, 4'h2, 16'h0000, 0,        4'h8, DB, 1'b0);
    vecs[15] = mk(4'hA, 4'h0, 16'h7050, '0, 4'h8, 16'h0000, 0,        4'h2, 32'h77, 1'b0);
    vecs[16] = mk(4'hA, 4'h0, 16'h7050, '0, 4'h2, 16'h0000, 0,        4'h8, 32'h77, 1'b0);
    vecs[17] = mk(4'hA, 4'h0, 16'h7050, '0, 4'h8, 16'h0000, 0,        4'h2, DB, 1'b0);
    vecs[18] = mk(4'h0, 4'h0, 16'h0000, '0, 4'h0, 16'h0000, 0,        4'h8, 32'h77, 1'b0);
    vecs[19] = mk(4'h1, 4'h1, 16'h0000, W0, 4'h1, 16'h0000, 0,        4'h0, 0,  1'b0);
    vecs[20] = mk(4'h1, 4'h0, 16'h0000, '0, 4'h1, 16'h0000, 0,        4'h0, 0,  1'b1);
    vecs[21] = mk(4'h0, 4'h0, 16'h0000, '0, 4'h0, 16'h0000, 0,        4'h1, 0,  1'b1);

    rst_n = 1'b0;
    drive(4'h0, 4'h0, 16'h0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready",   req_ready, 4'h0);
    chk("rst.bank_wr", bank_wr, 16'h0);
    chk("rst.din",     bank_din, 32'h0);
    chk("rst.rsp_v",   rsp_valid, 4'h0);
    chk("rst.rdata",   rsp_rdata, 32'h0);
    chk("rst.busy",    clr_busy, 1'b0);
    chk("rst.done",    clr_done, 1'b0);
    chk("rst.err",     err_wr0, 1'b0);
    rst_n = 1'b1;
    next_cyc();

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].wd, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d.ready", i),   req_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d.bank_wr", i), bank_wr,   vecs[i].e_wr);
      chk($sformatf("v%0d.din", i),     bank_din,  vecs[i].e_din);
      chk($sformatf("v%0d.rsp_v", i),   rsp_valid, vecs[i].e_rsp);
      chk($sformatf("v%0d.err", i),     err_wr0,   vecs[i].e_err);
      if (vecs[i].e_rsp != 4'h0) chk($sformatf("v%0d.rdata", i), rsp_rdata, vecs[i].e_rd);
      next_cyc();
    end

    // Fill R1..R15 from requester 0.
    for (int r = 1; r < 16; r++) begin
      drive(4'h1, 4'h1, 16'(r), {96'h0, 32'hA5000000 | 32'(r)}, 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d.bank_wr", r), bank_wr, 16'(1) << r);
      next_cyc();
    end
    // Read R9 from requester 1 right before clear; leaves rr_ptr at 2.
    drive(4'h2, 4'h0, 16'h0090, '0, 1'b0);
    @(negedge clk);
    chk("pre.ready", req_ready, 4'h2);
    next_cyc();
    drive(4'h1, 4'h0, 16'h0003, '0, 1'b1);
    @(negedge clk);
    chk("clr0.ready", req_ready, 4'h0);
    chk("clr0.busy",  clr_busy, 1'b0);
    chk("clr0.rsp_v", rsp_valid, 4'h2);
    chk("clr0.rdata", rsp_rdata, 32'hA5000009);
    chk("clr0.bank_wr", bank_wr, 16'h0);
    next_cyc();
    for (int k = 1; k < 16; k++) begin
      clr_start = (k <= 4);
      @(negedge clk);
      chk($sformatf("clr%0d.ready", k),   req_ready, 4'h0);
      chk($sformatf("clr%0d.busy", k),    clr_busy, 1'b1);
      chk($sformatf("clr%0d.bank_wr", k), bank_wr, 16'(1) << k);
      chk($sformatf("clr%0d.din", k),     bank_din, 32'h0);
      chk($sformatf("clr%0d.done", k),    clr_done, 1'b0);
      next_cyc();
    end
    drive(4'h5, 4'h0, 16'h0303, '0, 1'b0);
    @(negedge clk);
    chk("post.busy",  clr_busy, 1'b0);
    chk("post.done",  clr_done, 1'b1);
    chk("post.ready", req_ready, 4'h4);
    next_cyc();
    drive(4'h1, 4'h0, 16'h0001, '0, 1'b0);
    @(negedge clk);
    chk("post1.done",  clr_done, 1'b0);
    chk("post1.ready", req_ready, 4'h1);
    chk("post1.rsp_v", rsp_valid, 4'h4);
    chk("post1.rdata", rsp_rdata, 32'h0);
    next_cyc();
    for (int r = 2; r < 17; r++) begin
      if (r < 16) drive(4'h1, 4'h0, 16'(r), '0, 1'b0);
      else        drive(4'h0, 4'h0, 16'h0, '0, 1'b0);
      @(negedge clk);
      chk($sformatf("rdclr%0d.rsp_v", r - 1), rsp_valid, 4'h1);
      chk($sformatf("rdclr%0d.rdata", r - 1), rsp_rdata, 32'h0);
      next_cyc();
    end

    // Reset in the 7th CLEAR cycle.
    drive(4'h0, 4'h0, 16'h0, '0, 1'b1);
    next_cyc();
    clr_start = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("rclr%0d.bank_wr", k), bank_wr, 16'(1) << k);
      next_cyc();
    end
    chk("rclr7.err", err_wr0, 1'b1);
    chk("rclr7.busy_pre", clr_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst7.busy",    clr_busy, 1'b0);
    chk("rst7.rsp_v",   rsp_valid, 4'h0);
    chk("rst7.err",     err_wr0, 1'b0);
    chk("rst7.bank_wr", bank_wr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    drive(4'hF, 4'h0, 16'h5555, '0, 1'b0);
    @(negedge clk);
    chk("rel.ready", req_ready, 4'h1);
    chk("rel.busy",  clr_busy, 1'b0);
    chk("rel.bank_wr", bank_wr, 16'h0);
    next_cyc();
    drive(4'h0, 4'h0, 16'h0, '0, 1'b0);
    @(negedge clk);
    chk("rel.rsp_v", rsp_valid, 4'h1);
    chk("rel.rdata", rsp_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
